// File: rtl/dlsc_dma_rdarb_pkg.sv
// Shared types and helpers for the DMA read-port arbiter.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package dlsc_dma_rdarb_pkg;

  // AXI read response width and encodings.
  localparam int RESP_W = 2;
  localparam logic [RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

  // Ceiling log2, used for index and count widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((32'(1) << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dlsc_dma_rdarb_if.sv
// AXI read (AR+R) bundle; N lanes of valid/ready, N packed address/length fields,
// shared R last/data/resp. Latency: none (wires only). Backpressure: plain valid/ready.
// Modports: master drives AR and r_ready; slave drives ar_ready and the R payload.
interface dlsc_dma_rdarb_if
  import dlsc_dma_rdarb_pkg::*;
#(
  parameter int N    = 1,
  parameter int ADDR = 32,
  parameter int LEN  = 4,
  parameter int DATA = 32
);
  logic [N-1:0]      ar_valid;
  logic [N-1:0]      ar_ready;
  logic [N*ADDR-1:0] ar_addr;   // lane i at [i*ADDR +: ADDR]
  logic [N*LEN-1:0]  ar_len;    // lane i at [i*LEN +: LEN]
  logic [N-1:0]      r_valid;
  logic [N-1:0]      r_ready;
  logic              r_last;
  logic [DATA-1:0]   r_data;
  logic [RESP_W-1:0] r_resp;

  modport master (
    output ar_valid, ar_addr, ar_len, r_ready,
    input  ar_ready, r_valid, r_last, r_data, r_resp
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, r_ready,
    output ar_ready, r_valid, r_last, r_data, r_resp
  );
endinterface

// File: rtl/dlsc_dma_rdarb_rr_select.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping; one-hot + index.
// Latency: combinational. Backpressure: en_i low forces an empty grant.
// Ports: req_i, ptr_i, en_i in; gnt_o, idx_o, vld_o out.
// Macro DLSC_DMA_RDARB_PRIO_EN: request 0 wins outright and is excluded from the rotation.
module dlsc_dma_rdarb_rr_select
  import dlsc_dma_rdarb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int PSB   = clog2(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [PSB-1:0]   ptr_i,
  input  logic             en_i,
  output logic [PORTS-1:0] gnt_o,
  output logic [PSB-1:0]   idx_o,
  output logic             vld_o
);
  logic [PORTS-1:0] rr_req;

  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    vld_o  = 1'b0;
    rr_req = req_i;
`ifdef DLSC_DMA_RDARB_PRIO_EN
    rr_req[0] = 1'b0;
    if (en_i && req_i[0]) begin
      vld_o    = 1'b1;
      gnt_o[0] = 1'b1;
    end
`endif
    for (int k = 0; k < PORTS; k++) begin
      logic [PSB-1:0] j;
      j = PSB'((int'(ptr_i) + k) % PORTS);
      if (en_i && !vld_o && rr_req[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end
endmodule

// File: rtl/dlsc_fifo.sv
// Generic synchronous FIFO, 2**ADDR entries of DATA bits, optional occupancy count.
// Latency: 1 cycle push-to-visible; rd_data shows the head combinationally.
// Backpressure: caller must not push when full or pop when empty (guarded anyway).
// Ports: clk/rst, wr_push/wr_data, rd_pop/rd_data/rd_empty, rd_count (0 when COUNT=0).
module dlsc_fifo #(
  parameter int DATA  = 8,
  parameter int ADDR  = 4,
  parameter int COUNT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_push,
  input  logic [DATA-1:0] wr_data,
  input  logic            rd_pop,
  output logic [DATA-1:0] rd_data,
  output logic            rd_empty,
  output logic [ADDR:0]   rd_count
);
  localparam logic [ADDR:0] DEPTH = (ADDR+1)'(1) << ADDR;

  logic [DATA-1:0] mem_q [2**ADDR];
  logic [ADDR-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR:0]   cnt_q;
  logic            push_ok, pop_ok;

  assign push_ok  = wr_push && (cnt_q != DEPTH);
  assign pop_ok   = rd_pop && (cnt_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_empty = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR'(1);
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + (ADDR+1)'(1);
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - (ADDR+1)'(1);
    end
  end

  if (COUNT != 0) begin : g_count
    assign rd_count = cnt_q;
  end else begin : g_nocount
    assign rd_count = '0;
  end
endmodule

// File: rtl/dlsc_dma_rdarb.sv
// Shares one AXI read port between PORTS requesters: RR AR arbitration, in-order R routing.
// Latency: AR 1 cycle (registered slice, 1 burst/cycle); R combinational pass-through.
// Backpressure: grants stop while the AR slot is held or MOT bursts are outstanding;
//   a head requester not ready on R stalls the memory side.
// Ports: clk, rst (sync, active high); in_bus = requester side (slave modport),
//   out_bus = memory side (master modport, single lane).
// Macro DLSC_DMA_RDARB_PRIO_EN: requester 0 gets strict priority, the rest rotate.
module dlsc_dma_rdarb
  import dlsc_dma_rdarb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int ADDR  = 32,
  parameter int LEN   = 4,
  parameter int DATA  = 32,
  parameter int MOT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  dlsc_dma_rdarb_if.slave  in_bus,
  dlsc_dma_rdarb_if.master out_bus
);
  localparam int PSB  = clog2(PORTS);
  localparam int MOTB = clog2(MOT);
  localparam logic [MOTB:0] MOT_CNT = (MOTB+1)'(MOT);

  logic            ar_vld_q, ar_vld_d;
  logic [ADDR-1:0] ar_addr_q, ar_addr_d;
  logic [LEN-1:0]  ar_len_q, ar_len_d;
  logic [PSB-1:0]  ptr_q, ptr_d;

  logic             slot_free, can_issue, gnt_vld;
  logic [PORTS-1:0] gnt;
  logic [PSB-1:0]   gnt_idx;
  logic [PSB-1:0]   head;
  logic             fifo_empty;
  logic [MOTB:0]    outstanding;
  logic [PORTS-1:0] r_vld;
  logic             r_rdy, r_pop;

  // ---------------- AR arbitration ----------------
  assign slot_free = !ar_vld_q || out_bus.ar_ready;
  assign can_issue = !rst && slot_free && (outstanding < MOT_CNT);

  dlsc_dma_rdarb_rr_select #(.PORTS(PORTS), .PSB(PSB)) u_rr (
    .req_i (in_bus.ar_valid),
    .ptr_i (ptr_q),
    .en_i  (can_issue),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  assign in_bus.ar_ready = gnt;

  always_comb begin
    ptr_d     = ptr_q;
    ar_vld_d  = ar_vld_q;
    ar_addr_d = ar_addr_q;
    ar_len_d  = ar_len_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == PSB'(PORTS-1)) ? '0 : gnt_idx + PSB'(1);
`ifdef DLSC_DMA_RDARB_PRIO_EN
      // Port 0 wins outside the rotation, so it leaves the pointer alone;
      // the pointer never parks on port 0.
      if (gnt_idx == '0)      ptr_d = ptr_q;
      else if (ptr_d == '0)   ptr_d = PSB'(1);
`endif
      ar_vld_d = 1'b1;
      for (int i = 0; i < PORTS; i++) begin
        if (gnt[i]) begin
          ar_addr_d = in_bus.ar_addr[i*ADDR +: ADDR];
          ar_len_d  = in_bus.ar_len[i*LEN +: LEN];
        end
      end
    end else if (out_bus.ar_ready) begin
      ar_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_vld_q  <= 1'b0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ptr_q     <= '0;
    end else begin
      ar_vld_q  <= ar_vld_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q  <= ar_len_d;
      ptr_q     <= ptr_d;
    end
  end

  assign out_bus.ar_valid = ar_vld_q;
  assign out_bus.ar_addr  = ar_addr_q;
  assign out_bus.ar_len   = ar_len_q;

  // ---------------- grant-ID FIFO ----------------
  // Occupancy doubles as the outstanding-burst count.
  dlsc_fifo #(.DATA(PSB), .ADDR(MOTB), .COUNT(1)) u_gnt_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_push  (gnt_vld),
    .wr_data  (gnt_idx),
    .rd_pop   (r_pop),
    .rd_data  (head),
    .rd_empty (fifo_empty),
    .rd_count (outstanding)
  );

  // ---------------- R routing ----------------
  // An empty FIFO means no burst is owed; stray beats are stalled, not dropped.
  always_comb begin
    r_vld = '0;
    if (out_bus.r_valid && !fifo_empty) r_vld[head] = 1'b1;
  end

  assign r_rdy = !fifo_empty && in_bus.r_ready[head];
  assign r_pop = out_bus.r_valid && r_rdy && out_bus.r_last;

  assign in_bus.r_valid = r_vld;
  assign in_bus.r_last  = out_bus.r_last;
  assign in_bus.r_data  = out_bus.r_data;
  assign in_bus.r_resp  = out_bus.r_resp;
  assign out_bus.r_ready = r_rdy;
endmodule

// File: tb/tb_dlsc_dma_rdarb.sv
module tb_dlsc_dma_rdarb;
  import dlsc_dma_rdarb_pkg::*;

  localparam int PORTS = 4;
  localparam int ADDR  = 32;
  localparam int LEN   = 4;
  localparam int DATA  = 32;
  localparam int MOT   = 16;

  logic clk;
  logic rst;

  dlsc_dma_rdarb_if #(.N(PORTS), .ADDR(ADDR), .LEN(LEN), .DATA(DATA)) in_bus ();
  dlsc_dma_rdarb_if #(.N(1),     .ADDR(ADDR), .LEN(LEN), .DATA(DATA)) out_bus ();

  dlsc_dma_rdarb #(.PORTS(PORTS), .ADDR(ADDR), .LEN(LEN), .DATA(DATA), .MOT(MOT)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_bus  (in_bus),
    .out_bus (out_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR-1:0] port_addr(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [LEN-1:0] port_len(input int i);
    return LEN'(i + 1);
  endfunction

  typedef struct {
    logic [PORTS-1:0] vld;
    logic             ordy;
    logic [PORTS-1:0] exp_rdy;
    logic             exp_ovld;
    int               exp_port;
  } ar_vec_t;

  typedef struct {
    logic [PORTS-1:0] rrdy;
    logic             last;
    logic [PORTS-1:0] exp_rvld;
    logic             exp_ordy;
  } r_vec_t;

  ar_vec_t ar_tab[17];
  r_vec_t  r_tab[9];

  // Watchdog: the stimulus is fixed-length, this only guards against a stuck simulator.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    logic multi;

    // ---- vector tables ----
`ifdef DLSC_DMA_RDARB_PRIO_EN
    for (int k = 0; k < 17; k++) begin
      ar_tab[k].vld      = (k < 11) ? 4'hF : (k < 15) ? 4'h9 : 4'h0;
      ar_tab[k].ordy     = (k >= 5 && k <= 9) ? 1'b0 : 1'b1;
      ar_tab[k].exp_rdy  = (k < 15 && ar_tab[k].ordy) ? 4'b0001 : 4'b0000;
      ar_tab[k].exp_ovld = (k != 0 && k != 16);
      ar_tab[k].exp_port = 0;
    end
`else
    ar_tab[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 0};
    ar_tab[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 0};
    ar_tab[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 1};
    ar_tab[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2};
    ar_tab[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 3};
    for (int k = 5; k < 10; k++) ar_tab[k] = '{4'hF, 1'b0, 4'b0000, 1'b1, 0};
    ar_tab[10] = '{4'hF, 1'b1, 4'b0010, 1'b1, 0};
    ar_tab[11] = '{4'h9, 1'b1, 4'b1000, 1'b1, 1};
    ar_tab[12] = '{4'h9, 1'b1, 4'b0001, 1'b1, 3};
    ar_tab[13] = '{4'h9, 1'b1, 4'b1000, 1'b1, 0};
    ar_tab[14] = '{4'h9, 1'b1, 4'b0001, 1'b1, 3};
    ar_tab[15] = '{4'h0, 1'b1, 4'b0000, 1'b1, 0};
    ar_tab[16] = '{4'h0, 1'b1, 4'b0000, 1'b0, 0};
`endif
    // Port 2 burst (4 beats) then port 0 burst (2 beats), with stalls and a stray beat.
    r_tab[0] = '{4'b1011, 1'b0, 4'b0100, 1'b0};
    r_tab[1] = '{4'b1111, 1'b0, 4'b0100, 1'b1};
    r_tab[2] = '{4'b1111, 1'b0, 4'b0100, 1'b1};
    r_tab[3] = '{4'b1111, 1'b0, 4'b0100, 1'b1};
    r_tab[4] = '{4'b1111, 1'b1, 4'b0100, 1'b1};
    r_tab[5] = '{4'b1111, 1'b0, 4'b0001, 1'b1};
    r_tab[6] = '{4'b1110, 1'b0, 4'b0001, 1'b0};
    r_tab[7] = '{4'b1111, 1'b1, 4'b0001, 1'b1};
    r_tab[8] = '{4'b1111, 1'b0, 4'b0000, 1'b0};

    // ---- reset ----
    rst = 1'b1;
    for (int i = 0; i < PORTS; i++) begin
      in_bus.ar_addr[i*ADDR +: ADDR] = port_addr(i);
      in_bus.ar_len[i*LEN +: LEN]    = port_len(i);
    end
    in_bus.ar_valid  = 4'hF;
    in_bus.r_ready   = 4'hF;
    out_bus.ar_ready = 1'b1;
    out_bus.r_valid  = 1'b1;
    out_bus.r_last   = 1'b0;
    out_bus.r_data   = '0;
    out_bus.r_resp   = AXI_RESP_OKAY;
    tick();
    tick();
    chk("rst_out_ar_valid", 64'(out_bus.ar_valid), 64'd0);
    chk("rst_in_ar_ready",  64'(in_bus.ar_ready),  64'd0);
    chk("rst_in_r_valid",   64'(in_bus.r_valid),   64'd0);
    chk("rst_out_r_ready",  64'(out_bus.r_ready),  64'd0);
    in_bus.ar_valid = '0;
    out_bus.r_valid = 1'b0;
    rst = 1'b0;
    tick();

    // ---- AR arbitration table: RR sweep, AR hold, two-port alternation ----
    for (int k = 0; k < 17; k++) begin
      in_bus.ar_valid  = ar_tab[k].vld;
      out_bus.ar_ready = ar_tab[k].ordy;
      #1;
      chk($sformatf("v%0d_in_ar_ready", k),  64'(in_bus.ar_ready),  64'(ar_tab[k].exp_rdy));
      chk($sformatf("v%0d_out_ar_valid", k), 64'(out_bus.ar_valid), 64'(ar_tab[k].exp_ovld));
      if (ar_tab[k].exp_ovld) begin
        chk($sformatf("v%0d_out_ar_addr", k), 64'(out_bus.ar_addr), 64'(port_addr(ar_tab[k].exp_port)));
        chk($sformatf("v%0d_out_ar_len", k),  64'(out_bus.ar_len),  64'(port_len(ar_tab[k].exp_port)));
      end
      tick();
    end

    // ---- reset with bursts outstanding: FIFO must come back empty ----
    in_bus.ar_valid = '0;
    out_bus.r_valid = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst2_in_r_valid",   64'(in_bus.r_valid),   64'd0);
    chk("rst2_out_r_ready",  64'(out_bus.r_ready),  64'd0);
    chk("rst2_out_ar_valid", 64'(out_bus.ar_valid), 64'd0);
    rst = 1'b0;
    out_bus.r_valid = 1'b0;
    tick();

    // ---- MOT limit ----
    in_bus.ar_valid  = 4'hF;
    out_bus.ar_ready = 1'b1;
    grants = 0;
    multi  = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (in_bus.ar_ready != '0) grants++;
      if (!$onehot0(in_bus.ar_ready)) multi = 1'b1;
      tick();
    end
    chk("mot_grants",       64'(grants), 64'(MOT));
    chk("mot_onehot",       64'(multi),  64'd0);
    chk("mot_ready_at_max", 64'(in_bus.ar_ready), 64'd0);
    out_bus.r_valid = 1'b1;
    out_bus.r_last  = 1'b1;
    out_bus.r_data  = 32'h5A5A_0001;
    #1;
    chk("mot_pop_in_r_valid",  64'(in_bus.r_valid),  64'b0001);
    chk("mot_pop_out_r_ready", 64'(out_bus.r_ready), 64'd1);
    chk("mot_pop_in_r_data",   64'(in_bus.r_data),   64'h5A5A_0001);
    tick();
    out_bus.r_valid = 1'b0;
    out_bus.r_last  = 1'b0;
    grants = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (in_bus.ar_ready != '0) grants++;
      tick();
    end
    chk("mot_grants_after_pop", 64'(grants), 64'd1);

    in_bus.ar_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // ---- R routing: port 2 len=3 then port 0 len=1 ----
    in_bus.ar_valid = 4'b0100;
    #1;
    chk("r_ar_grant2", 64'(in_bus.ar_ready), 64'b0100);
    tick();
    in_bus.ar_valid = 4'b0001;
    #1;
    chk("r_ar_grant0", 64'(in_bus.ar_ready), 64'b0001);
    chk("r_ar_addr2",  64'(out_bus.ar_addr), 64'(port_addr(2)));
    chk("r_ar_len2",   64'(out_bus.ar_len),  64'd3);
    tick();
    in_bus.ar_valid = '0;
    #1;
    chk("r_ar_addr0", 64'(out_bus.ar_addr), 64'(port_addr(0)));
    chk("r_ar_len0",  64'(out_bus.ar_len),  64'd1);
    out_bus.r_resp = AXI_RESP_SLVERR;
    for (int b = 0; b < 9; b++) begin
      in_bus.r_ready  = r_tab[b].rrdy;
      out_bus.r_valid = 1'b1;
      out_bus.r_last  = r_tab[b].last;
      out_bus.r_data  = 32'hD000_0000 + 32'(b);
      #1;
      chk($sformatf("b%0d_in_r_valid", b),  64'(in_bus.r_valid),  64'(r_tab[b].exp_rvld));
      chk($sformatf("b%0d_out_r_ready", b), 64'(out_bus.r_ready), 64'(r_tab[b].exp_ordy));
      chk($sformatf("b%0d_in_r_data", b),   64'(in_bus.r_data),   64'(32'hD000_0000 + 32'(b)));
      chk($sformatf("b%0d_in_r_last", b),   64'(in_bus.r_last),   64'(r_tab[b].last));
      chk($sformatf("b%0d_in_r_resp", b),   64'(in_bus.r_resp),   64'(AXI_RESP_SLVERR));
      tick();
    end
    out_bus.r_valid = 1'b0;
    out_bus.r_last  = 1'b0;
    in_bus.r_ready  = 4'hF;

    // ---- reset in the middle of a burst ----
    in_bus.ar_valid = 4'b0010;
    #1;
    chk("mid_grant1", 64'(in_bus.ar_ready), 64'b0010);
    tick();
    in_bus.ar_valid = '0;
    out_bus.r_valid = 1'b1;
    #1;
    chk("mid_beat_in_r_valid",  64'(in_bus.r_valid),  64'b0010);
    chk("mid_beat_out_r_ready", 64'(out_bus.r_ready), 64'd1);
    tick();
    in_bus.ar_valid = 4'hF;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ar_ready", 64'(in_bus.ar_ready), 64'd0);
    tick();
    chk("mid_rst_out_ar_valid", 64'(out_bus.ar_valid), 64'd0);
    chk("mid_rst_in_r_valid",   64'(in_bus.r_valid),   64'd0);
    chk("mid_rst_out_r_ready",  64'(out_bus.r_ready),  64'd0);
    rst = 1'b0;
    out_bus.r_valid = 1'b0;
    in_bus.ar_valid = 4'b1010;
    #1;
    chk("mid_rst_ptr_restart", 64'(in_bus.ar_ready), 64'b0010);
    tick();
    in_bus.ar_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
